// File: rtl/edge_irq_ctrl.sv
// edge_irq_ctrl: synchronised per-channel edge detector with sticky pend/ovf bits and a round-robin valid/ready event port.
// Define EDGE_IRQ_DEBOUNCE_EN to insert a DB_CYCLES stability filter between the synchroniser and the edge detector.
module edge_irq_ctrl #(
  parameter  int STAGE     = 2,
  parameter  int CH_NUM    = 8,
  parameter  int DB_CYCLES = 4,
  localparam int IDW       = $clog2(CH_NUM)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [CH_NUM-1:0]   dat_i,
  input  logic [2*CH_NUM-1:0] mode_i,
  input  logic [CH_NUM-1:0]   en_i,
  input  logic [CH_NUM-1:0]   clr_i,
  output logic                evt_valid_o,
  output logic [IDW-1:0]      evt_id_o,
  input  logic                evt_ready_i,
  output logic [CH_NUM-1:0]   pend_o,
  output logic [CH_NUM-1:0]   ovf_o,
  output logic                irq_o
);
  if (STAGE < 2 || CH_NUM < 2 || DB_CYCLES < 1) begin : g_bad_param
    $error("edge_irq_ctrl: invalid parameters");
  end
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state_q, state_d;
  logic [CH_NUM-1:0] sync_q [STAGE];
  logic [CH_NUM-1:0] sync_d [STAGE];
  logic [CH_NUM-1:0] s, det, prev_q, prev_d, hit, hs_ch, req;
  logic [CH_NUM-1:0] pend_q, pend_d, ovf_q, ovf_d;
  logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d, pick;
  logic [IDW-1:0] cand [CH_NUM];
  logic valid_q, valid_d, found, hs;
  assign s = sync_q[STAGE-1];
`ifdef EDGE_IRQ_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  logic [CW-1:0] cnt_q [CH_NUM];
  logic [CW-1:0] cnt_d [CH_NUM];
  logic [CH_NUM-1:0] f_q, f_d;
  // f only follows s after DB_CYCLES consecutive cycles of disagreement
  always_comb begin
    f_d = f_q;
    for (int n = 0; n < CH_NUM; n++) begin
      cnt_d[n] = (s[n] == f_q[n] || cnt_q[n] == CW'(DB_CYCLES - 1)) ? '0 : cnt_q[n] + 1'b1;
      f_d[n]   = (s[n] != f_q[n] && cnt_q[n] == CW'(DB_CYCLES - 1)) ? s[n] : f_q[n];
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      f_q <= '0;
      for (int n = 0; n < CH_NUM; n++) cnt_q[n] <= '0;
    end else begin
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end
  assign det = f_q;
`else
  assign det = s;
`endif
  always_comb begin
    sync_d[0] = dat_i;
    for (int i = 1; i < STAGE; i++) sync_d[i] = sync_q[i-1];
    prev_d = det;
    hs     = valid_q & evt_ready_i;
    hs_ch  = hs ? {{(CH_NUM-1){1'b0}}, 1'b1} << id_q : '0;
    for (int n = 0; n < CH_NUM; n++)
      hit[n] = en_i[n] & ((mode_i[2*n] & ~prev_q[n] & det[n]) | (mode_i[2*n+1] & prev_q[n] & ~det[n]));
    // a fresh hit beats both clear sources; clearing in the same cycle suppresses overflow
    pend_d = hit | (pend_q & ~clr_i & ~hs_ch);
    ovf_d  = (hit & pend_q & ~clr_i & ~hs_ch) | (ovf_q & ~clr_i);
    req    = pend_q & en_i;
    pick   = '0;
    found  = 1'b0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      cand[i] = IDW'((int'(ptr_q) + i) % CH_NUM);
      if (req[cand[i]]) begin
        pick  = cand[i];
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = OFFER;
        valid_d = 1'b1;
        id_d    = pick;
      end
    end else if (hs) begin
      state_d = IDLE;
      valid_d = 1'b0;
      ptr_d   = (id_q == IDW'(CH_NUM - 1)) ? '0 : id_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < STAGE; i++) sync_q[i] <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      state_q <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end
  assign evt_valid_o = valid_q;
  assign evt_id_o    = id_q;
  assign pend_o      = pend_q;
  assign ovf_o       = ovf_q;
  assign irq_o       = |req;
endmodule

// File: tb/tb_edge_irq_ctrl.sv
// tb_edge_irq_ctrl: directed plus random stimulus against a cycle-level reference model; offered ids checked through a scoreboard queue.
module tb_edge_irq_ctrl;
  localparam int STAGE = 2, CH = 8, DB = 4;
`ifdef EDGE_IRQ_DEBOUNCE_EN
  localparam int LAT = STAGE + DB;
`else
  localparam int LAT = STAGE;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ready = 1'b0;
  logic [CH-1:0] dat = '0, en = '0, clr = '0;
  logic [2*CH-1:0] mode = '0;
  logic evt_valid, irq;
  logic [2:0] evt_id;
  logic [CH-1:0] pend, ovf;
  always #5 clk = ~clk;
  edge_irq_ctrl #(.STAGE(STAGE), .CH_NUM(CH), .DB_CYCLES(DB)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .dat_i(dat), .mode_i(mode), .en_i(en), .clr_i(clr),
    .evt_valid_o(evt_valid), .evt_id_o(evt_id), .evt_ready_i(ready),
    .pend_o(pend), .ovf_o(ovf), .irq_o(irq)
  );
  int n_chk = 0, n_pass = 0;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endfunction
  // reference model: sample history as a queue, state as plain bits and ints
  logic [CH-1:0] hist [$];
  logic [CH-1:0] m_pend, m_ovf, m_dprev, m_f;
  int m_cnt [CH];
  bit m_valid;
  int m_id, m_ptr;
  int sbq [$];
  int seen [$];
  always @(posedge clk or negedge rst_n) begin : model
    logic [CH-1:0] d, sv, hit, hcl, np;
    bit hs, found;
    if (!rst_n) begin
      m_pend = '0; m_ovf = '0; m_dprev = '0; m_f = '0;
      m_valid = 0; m_id = 0; m_ptr = 0;
      foreach (m_cnt[n]) m_cnt[n] = 0;
      hist.delete();
      repeat (STAGE) hist.push_front('0);
      sbq.delete();
    end else begin
      sv = hist[STAGE-1];
`ifdef EDGE_IRQ_DEBOUNCE_EN
      d = m_f;
      for (int n = 0; n < CH; n++) begin
        if (sv[n] != m_f[n]) begin
          m_cnt[n]++;
          if (m_cnt[n] == DB) begin m_f[n] = sv[n]; m_cnt[n] = 0; end
        end else m_cnt[n] = 0;
      end
`else
      d = sv;
`endif
      hist.push_front(dat);
      void'(hist.pop_back());
      for (int n = 0; n < CH; n++)
        hit[n] = en[n] && ((mode[2*n] && d[n] && !m_dprev[n]) || (mode[2*n+1] && !d[n] && m_dprev[n]));
      m_dprev = d;
      hs = m_valid && ready;
      hcl = '0;
      if (hs) hcl[m_id] = 1'b1;
      np = hit | (m_pend & ~clr & ~hcl);
      m_ovf = (hit & m_pend & ~clr & ~hcl) | (m_ovf & ~clr);
      if (m_valid) begin
        if (hs) begin m_valid = 0; m_ptr = (m_id + 1) % CH; end
      end else begin
        found = 0;
        for (int i = 0; i < CH; i++)
          if (!found && m_pend[(m_ptr + i) % CH] && en[(m_ptr + i) % CH]) begin
            found = 1; m_id = (m_ptr + i) % CH;
          end
        if (found) begin m_valid = 1; sbq.push_back(m_id); end
      end
      m_pend = np;
    end
  end
  bit last_v = 0;
  always @(negedge clk) begin
    chk("pend", pend, m_pend);
    chk("ovf", ovf, m_ovf);
    chk("irq", irq, |(m_pend & en));
    chk("valid", evt_valid, m_valid);
    if (evt_valid && !last_v) begin
      chk("offer_expected", sbq.size() != 0, 1);
      if (sbq.size() != 0) chk("offer_id", evt_id, sbq.pop_front());
      seen.push_back(int'(evt_id));
    end
    last_v = evt_valid;
  end
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic do_reset();
    rst_n = 0; dat = '0; clr = '0; ready = 0;
    cyc(2);
    rst_n = 1;
    cyc(1);
  endtask
  task automatic chk_order(int e0, int e1, int e2, int len);
    int exp [3];
    exp = '{e0, e1, e2};
    chk("order_len", seen.size(), len);
    for (int i = 0; i < len; i++) chk("order_id", (i < seen.size()) ? seen[i] : 99, exp[i]);
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    cyc(2);
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_pend", pend, 0);
    chk("rst_irq", irq, 0);
    // single rising event on ch2, then accept it
    mode = 16'h5555; en = '1;
    do_reset();
    dat[2] = 1'b1;
    cyc(LAT + 1);
    chk("t1_pend", pend, 8'h04);
    chk("t1_irq", irq, 1);
    chk("t1_valid_early", evt_valid, 0);
    cyc(1);
    chk("t1_valid", evt_valid, 1);
    chk("t1_id", evt_id, 2);
    ready = 1;
    cyc(1);
    chk("t1_pend_clr", pend, 8'h00);
    chk("t1_valid_drop", evt_valid, 0);
    // round-robin order, then a wrapped second burst
    do_reset();
    seen.delete();
    ready = 1;
    dat = 8'h89;
    cyc(LAT + 10);
    chk_order(0, 3, 7, 3);
    dat = '0;
    cyc(LAT + 4);
    seen.delete();
    dat = 8'h81;
    cyc(LAT + 8);
    chk_order(0, 7, 0, 2);
    // both-edge pulse while stalled gives overflow; clr_i does not withdraw the offer
    do_reset();
    mode = 16'h000C;
    dat[1] = 1'b1;
    cyc(4);
    dat[1] = 1'b0;
    cyc(LAT + 1);
    chk("t3_pend", pend, 8'h02);
    chk("t3_ovf", ovf, 8'h02);
    chk("t3_valid", evt_valid, 1);
    clr = 8'h02;
    cyc(1);
    clr = '0;
    chk("t3_pend_clr", pend, 8'h00);
    chk("t3_ovf_clr", ovf, 8'h00);
    chk("t3_valid_hold", evt_valid, 1);
    chk("t3_id_hold", evt_id, 1);
    ready = 1;
    cyc(1);
    ready = 0;
    chk("t3_valid_done", evt_valid, 0);
    // disabled channel ignores edges; enabling on a high line is not an edge
    do_reset();
    mode = 16'h5555; en = 8'hEF;
    dat[4] = 1'b1;
    cyc(LAT + 3);
    chk("t4_pend_dis", pend, 8'h00);
    chk("t4_valid_dis", evt_valid, 0);
    en = '1;
    cyc(LAT + 3);
    chk("t4_pend_en", pend, 8'h00);
    chk("t4_valid_en", evt_valid, 0);
    // new edge on ch5 lands in the same cycle as its handshake
    do_reset();
    dat[5] = 1'b1;
    cyc(LAT + 2);
    dat[5] = 1'b0;
    cyc(LAT + 1);
    dat[5] = 1'b1;
    cyc(LAT);
    ready = 1;
    cyc(1);
    ready = 0;
    chk("t5_pend", pend, 8'h20);
    chk("t5_ovf", ovf, 8'h00);
    chk("t5_valid_drop", evt_valid, 0);
    cyc(1);
    chk("t5_reoffer", evt_valid, 1);
    chk("t5_reoffer_id", evt_id, 5);
    // reset in the middle of an offer
    do_reset();
    dat[6] = 1'b1;
    cyc(LAT + 2);
    chk("t6_valid", evt_valid, 1);
    chk("t6_id", evt_id, 6);
    rst_n = 0;
    #1;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_id", evt_id, 0);
    chk("t6_rst_pend", pend, 0);
    do_reset();
`ifdef EDGE_IRQ_DEBOUNCE_EN
    dat[3] = 1'b1;
    cyc(3);
    dat[3] = 1'b0;
    cyc(LAT + 4);
    chk("db_short", pend, 8'h00);
    dat[3] = 1'b1;
    cyc(6);
    dat[3] = 1'b0;
    cyc(LAT - 6);
    chk("db_long_early", pend, 8'h00);
    cyc(1);
    chk("db_long", pend, 8'h08);
    do_reset();
`endif
    // random traffic checked entirely by the model and scoreboard
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        mode = 16'($urandom);
        en = 8'($urandom | $urandom);
      end
      for (int n = 0; n < CH; n++) if ($urandom_range(0, 7) == 0) dat[n] = ~dat[n];
      ready = $urandom_range(0, 2) != 0;
      clr = ($urandom_range(0, 15) == 0) ? 8'($urandom) : '0;
      cyc(1);
    end
    clr = '0; en = '1; ready = 1;
    cyc(LAT + 40);
    chk("drain_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/edge_irq_ctrl.md
Name: edge_irq_ctrl

Overview:
- Multi-channel edge-event controller with per-channel edge-mode configuration.
- Synchronises CH_NUM asynchronous inputs, detects the configured edges and latches them as sticky pending bits.
- A round-robin scheduler serialises pending events onto one valid/ready event port.
- Sits between raw GPIO/peripheral status lines and an interrupt or DMA front end.

Parameters:
- STAGE, 2: synchroniser depth per channel (>=2).
- CH_NUM, 8: number of channels (>=2).
- DB_CYCLES, 4: debounce stability length in cycles. Used only with EDGE_IRQ_DEBOUNCE_EN. Must be >=1.
- Derived (not overridable): IDW = $clog2(CH_NUM).

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- dat_i  input  CH_NUM  asynchronous event lines.
- mode_i  input  2*CH_NUM  per-channel mode, channel n at [2n+1:2n]: 00 off, 01 rising, 10 falling, 11 both.
- en_i  input  CH_NUM  per-channel enable.
- clr_i  input  CH_NUM  single-cycle clear of pend/ovf per channel.
- evt_valid_o  output  1  event offered.
- evt_id_o  output  IDW  channel index of offered event.
- evt_ready_i  input  1  consumer accepts event.
- pend_o  output  CH_NUM  sticky pending bits.
- ovf_o  output  CH_NUM  sticky overflow bits.
- irq_o  output  1  OR of (pend_o & en_i).

Behaviour:
- Reset values:
  - sync chains, previous-value regs, pend_o, ovf_o, RR pointer: 0.
  - FSM: IDLE.
  - evt_valid_o = 0, evt_id_o = 0, irq_o = 0.
- Per channel: STAGE-flop sync -> value s; previous reg q <= s each cycle.
  - re = ~q & s; fe = q & ~s.
  - hit = en & ((mode[0] & re) | (mode[1] & fe)).
- Latency: dat_i change sampled at edge k -> pend set visible after edge k+STAGE.
- pend update, priority per cycle:
  - hit: set (wins over handshake clear and clr_i).
  - else clr_i: clear.
  - else accepted handshake on this channel: clear.
- ovf: set when hit while pend already 1 and no clear (handshake or clr_i) in the same cycle. Cleared only by clr_i.
- en low:
  - New edges are ignored.
  - Existing pend bits are retained but not offered, and excluded from irq_o.
  - The q register keeps tracking, so enabling while a line is high does not create a false edge.
- Mode change takes effect on the next detected edge; no retroactive events.
- FSM IDLE:
  - If any (pend & en) is set, pick the first set index at or after the RR pointer, wrapping from CH_NUM-1 to 0.
  - Register the choice into evt_id_o, assert evt_valid_o, go to OFFER.
- FSM OFFER:
  - evt_valid_o and evt_id_o are held stable until evt_valid_o & evt_ready_i.
  - On handshake: clear that pend bit (subject to the priority above), pointer <= id+1 with wrap at CH_NUM-1, deassert valid, go to IDLE.
- Maximum throughput: one event per 2 cycles.
- clr_i or en drop on the offered channel during OFFER: the offer is not withdrawn. The handshake completes and the clear is a no-op.
- evt_ready_i while in IDLE is ignored.
- Reset asserted mid-offer: immediate return to the reset values; the event is lost.
- irq_o is combinational from registered pend and en_i.

Optional Feature:
- Macro: EDGE_IRQ_DEBOUNCE_EN.
- Defined:
  - A per-channel counter sits between s and the detector.
  - The filtered value f updates to s only after s has differed from f for DB_CYCLES consecutive cycles. Any return to f resets the counter.
  - Edges are detected on f, so latency grows by DB_CYCLES.
  - Pulses shorter than DB_CYCLES produce no event.
- Undefined: no filter; DB_CYCLES is ignored; latency is exactly as stated above.

Test Plan:
- Reset, ch2 mode 01, en all 1, dat_i[2] 0->1 before edge k -> pend_o=0x04 and irq_o=1 after edge k+2. Then evt_valid_o=1 with evt_id_o=2 next cycle; ready=1 -> pend_o=0x00 and evt_valid_o=0.
- Channels 0, 3, 7 rise together, ready held 1 -> ids offered in order 0, 3, 7, one every 2 cycles. A second burst on 0 and 7 after pointer=0 (wrapped after id 7) -> order 0, 7.
- ch1 mode 11 with a pulse 1 -> 0 (each level 4 cycles), ready=0 -> pend_o[1]=1, ovf_o[1]=1. clr_i[1] -> both 0; evt_valid_o remains 1 until ready.
- ch4 en=0, rising edge -> pend_o[4]=0, no event. en[4]=1 with the line still high -> no event.
- Rising edge on ch5 in the same cycle as the handshake of id 5 -> pend_o[5] stays 1 and ch5 is offered again.
- EDGE_IRQ_DEBOUNCE_EN defined, DB_CYCLES=4: 3-cycle high pulse -> no pend. 6-cycle high pulse -> pend set STAGE+4 cycles after the rise.
